// File: rtl/control_sequencer.sv
// control_sequencer: Moore control FSM for a simple load/store datapath.
// Fetch (T0..T2), decode (T3), then execute for ld/ldi/st (T4..T7).
// Outputs decode from the registered state plus the live IR opcode field.
// Optional macro CTRL_MEM_WAIT_EN: when defined, T1, ld T6 and st T7 stall
// until mem_ready; when undefined those states are single-cycle and
// mem_ready is ignored.
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] instruction,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        PCin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        MDRin,
    output logic        MDRout,
    output logic        MD_read,
    output logic        ram_read,
    output logic        ram_write,
    output logic        IRin,
    output logic        Yin,
    output logic        Cout,
    output logic        BAout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        run,
    output logic        illegal_op,
    output logic [3:0]  step
);

    typedef enum logic [3:0] {
        T0   = 4'd0,
        T1   = 4'd1,
        T2   = 4'd2,
        T3   = 4'd3,
        T4   = 4'd4,
        T5   = 4'd5,
        T6   = 4'd6,
        T7   = 4'd7,
        HALT = 4'd15
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b10000;
    localparam logic [4:0] OP_LDI  = 5'b10001;
    localparam logic [4:0] OP_ST   = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Control word; one field per datapath strobe.
    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic pc_in;
        logic z_in;
        logic zlow_out;
        logic mdr_in;
        logic mdr_out;
        logic md_read;
        logic ram_read;
        logic ram_write;
        logic ir_in;
        logic y_in;
        logic c_out;
        logic ba_out;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic run;
        logic illegal_op;
    } ctrl_t;

    state_t     state, next_state;
    ctrl_t      c;
    logic [4:0] opcode;
    logic       is_ld, is_ldi, is_st, is_nop, is_halt, is_mem;
    logic       mem_done;

    // Only the opcode field steers sequencing; operand fields belong to the datapath.
    logic [26:0] unused_ir_fields;
    assign unused_ir_fields = instruction[26:0];

    assign opcode  = instruction[31:27];
    assign is_ld   = (opcode == OP_LD);
    assign is_ldi  = (opcode == OP_LDI);
    assign is_st   = (opcode == OP_ST);
    assign is_nop  = (opcode == OP_NOP);
    assign is_halt = (opcode == OP_HALT);
    assign is_mem  = is_ld | is_ldi | is_st;

`ifdef CTRL_MEM_WAIT_EN
    // Wait states complete in the cycle mem_ready is seen high.
    assign mem_done = mem_ready;
`else
    // Memory is assumed single-cycle; the strobe is kept only for port compatibility.
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_done         = 1'b1;
`endif

    // State register: clear returns to T0 from anywhere, including HALT and waits.
    always_ff @(posedge clock) begin
        if (clear) state <= T0;
        else       state <= next_state;
    end

    // Next-state and Moore control decode; clear blanks every control combinationally.
    always_comb begin
        next_state = state;
        c          = '0;
        c.run      = (state != HALT);
        case (state)
            T0: begin
                c.pc_out   = 1'b1;
                c.mar_in   = 1'b1;
                c.inc_pc   = 1'b1;
                c.z_in     = 1'b1;
                next_state = T1;
            end
            T1: begin
                c.zlow_out = 1'b1;
                c.pc_in    = 1'b1;
                c.ram_read = 1'b1;
                c.md_read  = 1'b1;
                c.mdr_in   = 1'b1;
                if (mem_done) next_state = T2;
            end
            T2: begin
                c.mdr_out  = 1'b1;
                c.ir_in    = 1'b1;
                next_state = T3;
            end
            T3: begin
                if (is_mem) begin
                    c.grb      = 1'b1;
                    c.ba_out   = 1'b1;
                    c.y_in     = 1'b1;
                    next_state = T4;
                end else if (is_nop) begin
                    next_state = T0;
                end else if (is_halt) begin
                    next_state = HALT;
                end else begin
                    c.illegal_op = 1'b1;
                    next_state   = T0;
                end
            end
            T4: begin
                // EA = Rb + sext(C): Y already holds Rb, ALU adds C into Z.
                if (is_mem) begin
                    c.c_out    = 1'b1;
                    c.z_in     = 1'b1;
                    next_state = T5;
                end else begin
                    next_state = T0;
                end
            end
            T5: begin
                if (is_ldi) begin
                    c.zlow_out = 1'b1;
                    c.gra      = 1'b1;
                    c.r_in     = 1'b1;
                    next_state = T0;
                end else if (is_ld || is_st) begin
                    c.zlow_out = 1'b1;
                    c.mar_in   = 1'b1;
                    next_state = T6;
                end else begin
                    next_state = T0;
                end
            end
            T6: begin
                if (is_ld) begin
                    c.ram_read = 1'b1;
                    c.md_read  = 1'b1;
                    c.mdr_in   = 1'b1;
                    if (mem_done) next_state = T7;
                end else if (is_st) begin
                    // MDR loads from the bus (Ra), not from memory.
                    c.gra      = 1'b1;
                    c.r_out    = 1'b1;
                    c.mdr_in   = 1'b1;
                    next_state = T7;
                end else begin
                    next_state = T0;
                end
            end
            T7: begin
                if (is_ld) begin
                    c.mdr_out  = 1'b1;
                    c.gra      = 1'b1;
                    c.r_in     = 1'b1;
                    next_state = T0;
                end else if (is_st) begin
                    c.ram_write = 1'b1;
                    if (mem_done) next_state = T0;
                end else begin
                    next_state = T0;
                end
            end
            HALT: begin
                next_state = HALT;
            end
            default: begin
                next_state = T0;
            end
        endcase
        if (clear) c = '0;
    end

    // Port fan-out of the control word.
    assign PCout      = c.pc_out;
    assign MARin      = c.mar_in;
    assign IncPC      = c.inc_pc;
    assign PCin       = c.pc_in;
    assign Zin        = c.z_in;
    assign Zlowout    = c.zlow_out;
    assign MDRin      = c.mdr_in;
    assign MDRout     = c.mdr_out;
    assign MD_read    = c.md_read;
    assign ram_read   = c.ram_read;
    assign ram_write  = c.ram_write;
    assign IRin       = c.ir_in;
    assign Yin        = c.y_in;
    assign Cout       = c.c_out;
    assign BAout      = c.ba_out;
    assign Gra        = c.gra;
    assign Grb        = c.grb;
    assign Grc        = c.grc;
    assign Rin        = c.r_in;
    assign Rout       = c.r_out;
    assign run        = c.run;
    assign illegal_op = c.illegal_op;
    assign step       = clear ? 4'd0 : state;

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 clock  input  1  system clock; all state changes on rising edge.
REQ-002 clear  input  1  synchronous, active-high reset.
REQ-003 instruction  input  32  IR contents from DataPath; opcode = instruction[31:27].
REQ-004 mem_ready  input  1  memory completion strobe; sampled only in memory-wait states.
REQ-005 Outputs, 1 bit each, drive DataPath controls: PCout MARin IncPC PCin Zin Zlowout MDRin MDRout MD_read ram_read ram_write IRin Yin Cout BAout Gra Grb Grc Rin Rout.
REQ-006 run  output  1  high in every state except HALT.
REQ-007 illegal_op  output  1  one-cycle pulse on an undecodable opcode.
REQ-008 step  output  4  current state code: T0..T7 = 0..7, HALT = 15.

Function
REQ-009 Moore FSM; every control output decodes from the registered state and opcode only; outputs not listed for a state are 0.
REQ-010 Opcodes: ld = 10000, ldi = 10001, st = 10010, nop = 11010, halt = 11011; all others are illegal.
REQ-011 T0: PCout, MARin, IncPC, Zin -> T1.
REQ-012 T1: Zlowout, PCin, ram_read, MD_read, MDRin; hold in T1 until mem_ready = 1, then -> T2.
REQ-013 T2: MDRout, IRin -> T3.
REQ-014 T3 decode: ld/ldi/st assert Grb, BAout, Yin -> T4; nop -> T0; halt -> HALT; illegal asserts illegal_op -> T0.
REQ-015 T4 (ld/ldi/st): Cout, Zin (EA = Rb + sign-extended C, computed by DataPath ALU ADD) -> T5.
REQ-016 T5: ldi asserts Zlowout, Gra, Rin -> T0; ld/st assert Zlowout, MARin -> T6.
REQ-017 T6: ld asserts ram_read, MD_read, MDRin and holds until mem_ready -> T7; st asserts Gra, Rout, MDRin (MD_read = 0) -> T7.
REQ-018 T7: ld asserts MDRout, Gra, Rin -> T0; st asserts ram_write and holds until mem_ready -> T0.
REQ-019 HALT: all controls 0, run = 0; stays in HALT until clear.
REQ-020 Latency, zero wait: ld 8 cycles, st 8, ldi 6, nop/illegal 4 (T0 to next T0).
REQ-021 Exactly one of {ram_read, ram_write} may be high in any cycle; ram_write is never high outside st T7.
REQ-022 mem_ready high outside wait states is ignored; mem_ready already high on wait-state entry completes the wait in that cycle.

Reset
REQ-023 clear = 1 at a rising edge -> state T0 at the next cycle, from any state including HALT and mid-wait.
REQ-024 While clear = 1, all control outputs, run and illegal_op are forced 0 combinationally; step reports 0.
REQ-025 Reset during st T7 abandons the write; ram_write is not asserted after the edge on which clear is sampled.

Configuration
REQ-026 Macro CTRL_MEM_WAIT_EN: defined -> T1, ld T6 and st T7 wait on mem_ready per REQ-012/017/018.
REQ-027 Undefined -> those states last exactly one cycle, mem_ready is ignored, and the port remains present but unused.

Verification
REQ-028 clear for 1 cycle, IR = 0x83100063 (ld), mem_ready tied 1 -> step 0,1,...,7,0; Gra and Rin high in T7 only; run = 1 throughout.
REQ-029 ld with mem_ready low for 3 cycles in T6 -> step holds at 6 for 4 cycles; ram_read high in all 4; total 11 cycles.
REQ-030 IR = 0x93100063 (st) -> T6 shows Rout, Gra, MDRin with MD_read = 0; T7 shows ram_write = 1 for exactly 1 cycle.
REQ-031 IR = 0x8B100063 (ldi) -> T5 shows Zlowout, Gra, Rin; next step = 0; 6 cycles total.
REQ-032 IR = 0xF8000000 (illegal) -> illegal_op = 1 in T3 only, then T0; IR = 0xD8000000 (halt) -> step = 15, run = 0 until clear.
REQ-033 Assert clear during st T7 with mem_ready low -> ram_write = 0 during clear; step = 0 in the next cycle.
